modred_wordserial: RTL and testbench

- Word-serial Montgomery reducer. Consumes the 2*DATA_SIZE-bit integer product from the multiplier stage; returns R = C_in * 2^(-DATA_SIZE) mod q.
- Processes one 16-bit digit per cycle, matching the multiplier's 16-bit DSP chunking.
- Sits between the integer multiplier and the butterfly/accumulator datapath of the NTT core.
- Valid/ready handshake on both sides.

---
 rtl/modred_wordserial.sv | 183 ++++++++++++++++++
 tb/tb_modred_wordserial.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modred_wordserial.sv
// Word-serial Montgomery reducer: R = C_in * 2^(-DATA_SIZE) mod q.
// Processes one 16-bit digit of the accumulator per iteration, L = DATA_SIZE/16
// iterations. Valid/ready handshake on input and output, no overlap between
// operations.
// Optional build macro MODRED_MREG_EN: registers the per-digit quotient m so
// each digit takes two cycles (compute m, then update T), which breaks the
// q_inv multiply -> m*q multiply path.
//
// state | meaning
// IDLE  | waiting for a product, in_ready high
// ITER  | one digit reduction per iteration (two cycles each with MODRED_MREG_EN)
// FINAL | conditional final subtraction, R is loaded
// DONE  | R presented with out_valid until out_ready

module modred_wordserial #(
    parameter int DATA_SIZE = 32,
    localparam int L = DATA_SIZE / 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*DATA_SIZE-1:0]   C_in,
    input  logic [DATA_SIZE-1:0]     q,
    input  logic [15:0]              q_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_SIZE-1:0]     R,
    output logic                     busy
);

    // Accumulator keeps one extra bit so the carry of T + m*q is never lost.
    localparam int TW = 2 * DATA_SIZE + 1;
    localparam int SW = TW + 1;
    localparam int MW = DATA_SIZE + 16;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [TW-1:0]          t_acc;
    logic [CW-1:0]          cnt;
    logic [DATA_SIZE-1:0]   r_reg;

    logic [15:0]            m_now;
    logic [15:0]            m_use;
    logic                   digit_step;
    logic [MW-1:0]          mq;
    logic [SW-1:0]          sum;
    logic [TW-1:0]          t_shift;
    logic                   last_digit;
    logic [TW-1:0]          q_ext;
    logic                   t_ge_q;
    logic [DATA_SIZE-1:0]   t_minus_q;
    logic [DATA_SIZE-1:0]   r_final;

`ifdef MODRED_MREG_EN
    logic [15:0]            m_reg;
    logic                   phase;
`endif

    // Digit quotient and the exact shift-by-16 accumulator update.
    always_comb begin
        m_now = 16'(t_acc[15:0] * q_inv);
`ifdef MODRED_MREG_EN
        m_use      = m_reg;
        digit_step = phase;
`else
        m_use      = m_now;
        digit_step = 1'b1;
`endif
        mq         = {{DATA_SIZE{1'b0}}, m_use} * {16'b0, q};
        sum        = {1'b0, t_acc} + {{(SW - MW){1'b0}}, mq};
        // Low 16 bits of sum are zero by construction of m.
        t_shift    = TW'(sum >> 16);
        last_digit = (cnt == CW'(L - 1)) && digit_step;
    end

    // Final conditional subtraction; the precondition bounds T below 2q.
    always_comb begin
        q_ext     = {{(DATA_SIZE + 1){1'b0}}, q};
        t_ge_q    = (t_acc >= q_ext);
        t_minus_q = DATA_SIZE'(t_acc - q_ext);
        r_final   = t_ge_q ? t_minus_q : t_acc[DATA_SIZE-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (last_digit) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Accumulator, digit counter and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_acc <= '0;
            cnt   <= '0;
            r_reg <= '0;
`ifdef MODRED_MREG_EN
            m_reg <= '0;
            phase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        t_acc <= {1'b0, C_in};
                        cnt   <= '0;
`ifdef MODRED_MREG_EN
                        phase <= 1'b0;
`endif
                    end
                end
                ITER: begin
`ifdef MODRED_MREG_EN
                    if (!phase) begin
                        m_reg <= m_now;
                        phase <= 1'b1;
                    end else begin
                        t_acc <= t_shift;
                        cnt   <= cnt + CW'(1);
                        phase <= 1'b0;
                    end
`else
                    t_acc <= t_shift;
                    cnt   <= cnt + CW'(1);
`endif
                end
                FINAL: begin
                    r_reg <= r_final;
                end
                default: begin
                end
            endcase
        end
    end

    assign R = r_reg;

endmodule

// File: tb/tb_modred_wordserial.sv
// Scoreboard bench for modred_wordserial (DATA_SIZE=32): directed vectors,
// backpressure, mid-operation reset and a random regression against an
// independent halving-based model of C * 2^-32 mod q.

module tb_modred_wordserial;

    localparam int DS = 32;
`ifdef MODRED_MREG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif
    localparam int N_RAND = 3000;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2*DS-1:0] C_in;
    logic [DS-1:0]   q;
    logic [15:0]     q_inv;
    logic            out_valid;
    logic            out_ready;
    logic [DS-1:0]   R;
    logic            busy;

    logic [DS-1:0]   exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              n_sent = 0;
    int              n_out = 0;
    bit              rand_ready = 1'b0;

    modred_wordserial #(.DATA_SIZE(DS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C_in      (C_in),
        .q         (q),
        .q_inv     (q_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // C * 2^-32 mod q by halving modulo q 32 times.
    function automatic logic [DS-1:0] golden(input logic [63:0] c, input logic [DS-1:0] qq);
        logic [32:0] x;
        x = 33'(c % {32'b0, qq});
        for (int i = 0; i < 32; i++) begin
            if (x[0]) x = (x + {1'b0, qq}) >> 1;
            else      x = x >> 1;
        end
        return x[DS-1:0];
    endfunction

    // -q^-1 mod 2^16 by Newton iteration.
    function automatic logic [15:0] calc_qinv(input logic [DS-1:0] qq);
        logic [15:0] a;
        logic [15:0] inv;
        a   = qq[15:0];
        inv = a;
        for (int i = 0; i < 4; i++) inv = inv * (16'd2 - a * inv);
        return 16'd0 - inv;
    endfunction

    // Monitor: each output handshake pops and compares one expected result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output actual=%0h required=no_output", R);
            end else begin
                check("result", {32'b0, R}, {32'b0, exp_q.pop_front()});
            end
        end
    end

    // Random out_ready during the regression phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [63:0] c, input logic [DS-1:0] qq, input logic [15:0] qi,
                        input bit push, input logic [DS-1:0] e);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", {63'b0, in_ready}, 64'd1);
        if (!in_ready) return;
        C_in     = c;
        q        = qq;
        q_inv    = qi;
        in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            n_sent++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_reached", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int              lat;
        logic [DS-1:0]   r_hold;
        logic [DS-1:0]   rq;
        logic [DS-1:0]   hi;
        logic [DS-1:0]   lo;
        logic [63:0]     rc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        C_in      = '0;
        q         = 32'd7;
        q_inv     = 16'h9249;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_R", {32'b0, R}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        reset = 1'b0;

        // Directed small modulus with latency check.
        out_ready = 1'b1;
        send(64'h5_0000_0000, 32'd7, 16'h9249, 1'b1, 32'd5);
        wait_out(lat);
        check("latency", 64'(lat), 64'(LAT));
        check("busy_in_done", {63'b0, busy}, 64'd1);

        // Final-subtract boundaries.
        send(64'h1_0000_0000, 32'hFFFF_FFFB, 16'hCCCD, 1'b1, 32'd1);
        send(64'hFFFF_FFFA_0000_0000, 32'hFFFF_FFFB, 16'hCCCD, 1'b1, 32'hFFFF_FFFA);
        send(64'h0000_0000_FFFF_FFFB, 32'hFFFF_FFFB, 16'hCCCD, 1'b1, 32'd0);

        // Zero and multiple of q.
        send(64'd0, 32'd7, 16'h9249, 1'b1, 32'd0);
        send(64'd14, 32'd7, 16'h9249, 1'b1, 32'd0);

        // Backpressure: hold DONE for 10 cycles with a pending request.
        wait_idle();
        out_ready = 1'b0;
        send(64'h4_0000_0000, 32'd7, 16'h9249, 1'b1, 32'd4);
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'(LAT));
        r_hold   = R;
        check("bp_R_value", {32'b0, r_hold}, 64'd4);
        C_in     = 64'h6_0000_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {63'b0, out_valid}, 64'd1);
            check("bp_R_stable", {32'b0, R}, {32'b0, r_hold});
            check("bp_in_ready", {63'b0, in_ready}, 64'd0);
        end
        exp_q.push_back(32'd6);
        n_sent++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {63'b0, out_valid}, 64'd0);
        check("bp_release_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        check("bp_new_accept", {63'b0, busy}, 64'd1);
        in_valid = 1'b0;
        wait_idle();

        // Reset during the second ITER cycle aborts the operation.
        send(64'h5_0000_0000, 32'd7, 16'h9249, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_out_valid", {63'b0, out_valid}, 64'd0);
        check("abort_R", {32'b0, R}, 64'd0);
        check("abort_in_ready", {63'b0, in_ready}, 64'd1);
        check("abort_busy", {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(64'h3_0000_0000, 32'd7, 16'h9249, 1'b1, 32'd3);
        wait_idle();

        // Random regression, back-to-back with random out_ready.
        rand_ready = 1'b1;
        for (int i = 0; i < N_RAND; i++) begin
            if (i % 4 == 0) rq = 32'($urandom_range(3, 65535)) | 32'd1;
            else            rq = $urandom | 32'd1;
            hi = $urandom % rq;
            lo = $urandom;
            rc = {hi, lo};
            send(rc, rq, calc_qinv(rq), 1'b1, golden(rc, rq));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        check("output_count", 64'(n_out), 64'(n_sent));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
